ones_pattern_gen: RTL and testbench
===================================

# ones_pattern_gen

Sequential thermometer-code generator that converts an (N+1)-bit ones count into a (2^(N+1)−1)-bit vector whose lowest `count` bits are 1 and the rest 0. It is the encoding end of the ones-counter datapath: any vector it produces, fed to the ones counter with the same N, must return the original count. It fills the vector CHUNK bits per clock under a start/busy/done handshake, so it is used where a wide combinational expander is too costly.

## Interface

Parameters:
- N, default 6; count width is N+1, and vector length L = 2^(N+1)−1 (127 at default).
- CHUNK, default 8; vector bits written per FILL cycle. Legal range 1..L.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE or DONE.
- count  input  N+1  number of ones. Latched when start is accepted; ignored at all other times.
- busy  output  1  high while in FILL.
- done  output  1  one-cycle pulse after the last chunk is written.
- vec  output  L  result vector. Registered, and held stable from DONE until the next accepted start.

## Operation

- Internal registers:
  - state (IDLE, FILL, DONE)
  - cnt_q (N+1 bits), the latched count
  - ptr, the chunk base index. Width N+2 bits, so ptr+CHUNK never wraps.
  - vec register
- Number of chunks: NCH = ceil(L/CHUNK), which is 16 at the defaults.
- IDLE: busy=0, done=0.
  - start=1 → go to FILL; cnt_q←count, ptr←0, vec←0.
  - Otherwise stay in IDLE; vec holds.
- FILL: busy=1.
  - Each cycle, for j in 0..CHUNK−1 with ptr+j < L: vec[ptr+j] ← (ptr+j < cnt_q).
  - Bit positions ≥ L in the final partial chunk are discarded.
  - ptr ← ptr+CHUNK.
  - After the chunk at base (NCH−1)·CHUNK is written → go to DONE.
- DONE: done=1, busy=0, vec is final.
  - start=1 → FILL, with the same actions as in IDLE (back-to-back operation).
  - Otherwise → IDLE.
- start while in FILL is ignored and not queued. count changes during FILL have no effect.
- Arithmetic: every comparison is unsigned at N+2 bits.
  - count=0 gives an all-zero vector.
  - count=L gives an all-ones vector.
  - Count values are never out of range, because the maximum (N+1)-bit value equals L.

## Timing

- Reset state: asynchronous on rst high.
  - state=IDLE, ptr=0, cnt_q=0, vec=0, busy=0, done=0.
  - Reset asserted during FILL aborts the operation. vec reads 0 from the reset assertion until the next completed fill.
- Start accepted at rising edge t:
  - busy=1 from edge t up to edge t+NCH.
  - Chunk k is written at edge t+1+k (k = 0..NCH−1).
  - After edge t+NCH, state=DONE, done=1, and vec is final.
  - After edge t+NCH+1, done=0.
- Latency from start to done is NCH+1 edges, which is 17 at the defaults.
- Back-to-back: start high during DONE gives the next busy period with no idle gap. That edge clears vec, so the previous result is visible for exactly the DONE cycle.
- During FILL, vec shows a partially filled value. Consumers must sample vec only while done=1, or at any time while in IDLE.

## Structure

- Package ones_pattern_pkg contains:
  - state enum: IDLE, FILL, DONE
  - function vec_len(N), returning 2^(N+1)−1
  - function num_chunks(N, CHUNK), returning NCH
- Sub-module thermo_chunk (combinational):
  - Parameters: N, CHUNK.
  - Inputs: base (N+2 bits), cnt (N+1 bits).
  - Output: CHUNK bits, where bit j = (base+j < cnt).
  - It is instantiated once and drives the write lanes in FILL.
- The top level holds the FSM, ptr, cnt_q, and the vec register, with a masked write of CHUNK lanes at index ptr.

## Test plan

- Reset: pulse rst mid-FILL at count=100 → on the same cycle busy=0, done=0, vec=0, state IDLE; start count=5 afterwards completes normally.
- count=0 → after 17 edges done=1, vec=0, done high exactly one cycle.
- count=127 → vec is all ones, including bits 120..126 of the partial last chunk.
- count=9 → vec=0x1FF in the low bits with all other bits 0. Intermediate check: after chunk 0, vec[7:0]=0xFF and vec[8]=0; after chunk 1, vec[8]=1.
- Back-to-back: start count=64, hold start high through DONE with count=3 → the second fill begins with no idle cycle; done pulses at edges 17 and 34 (relative); the final vec has only bits 2:0 set. Also check that start and count changes during FILL are ignored.
- Round trip, random 200 counts with CHUNK ∈ {1, 8, 127}: the ones counter applied to vec at done equals count; busy length equals NCH.

Source files
------------

// File: rtl/ones_pattern_pkg.sv
// Shared types and sizing helpers for the thermometer-code generator.
// Vector length and chunk count derive from N and CHUNK only.
package ones_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  function automatic int vec_len(input int n);
    return (1 << (n + 1)) - 1;
  endfunction

  function automatic int num_chunks(input int n, input int chunk);
    return (vec_len(n) + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/thermo_chunk.sv
// Combinational thermometer slice: lane j is set when base+j < cnt.
// Compares run at N+2 bits so base+j never wraps.
module thermo_chunk
  import ones_pattern_pkg::*;
#(
  parameter int N     = 6,
  parameter int CHUNK = 8
) (
  input  logic [N+1:0]     base,
  input  logic [N:0]       cnt,
  output logic [CHUNK-1:0] lanes
);

  localparam int W = N + 2;

  for (genvar j = 0; j < CHUNK; j++) begin : g_lane
    assign lanes[j] = (base + W'(j)) < {1'b0, cnt};
  end

endmodule

// File: rtl/ones_pattern_gen.sv
// Chunked thermometer-code generator with start/busy/done handshake.
// Writes CHUNK bits of vec per FILL cycle at base index ptr.
module ones_pattern_gen
  import ones_pattern_pkg::*;
#(
  parameter  int N     = 6,
  parameter  int CHUNK = 8,
  localparam int L     = vec_len(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N:0]   count,
  output logic         busy,
  output logic         done,
  output logic [L-1:0] vec
);

  localparam int NCH = num_chunks(N, CHUNK);
  localparam int W   = N + 2;
  localparam logic [W-1:0] STEP = W'(CHUNK);
  localparam logic [W-1:0] LAST = W'((NCH - 1) * CHUNK);

  state_t           state;
  logic [N:0]       cnt_q;
  logic [W-1:0]     ptr;
  logic [L-1:0]     vec_q;
  logic [CHUNK-1:0] lanes;
  logic [L-1:0]     wdat;
  logic [L-1:0]     wmsk;
  logic [L-1:0]     vec_nxt;

  thermo_chunk #(
    .N    (N),
    .CHUNK(CHUNK)
  ) u_chunk (
    .base (ptr),
    .cnt  (cnt_q),
    .lanes(lanes)
  );

  // Lanes past L in the last partial chunk fall off the top here.
  always_comb begin
    wdat    = L'({{L{1'b0}}, lanes} << ptr);
    wmsk    = L'({{L{1'b0}}, {CHUNK{1'b1}}} << ptr);
    vec_nxt = (vec_q & ~wmsk) | (wdat & wmsk);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt_q <= '0;
      ptr   <= '0;
      vec_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= FILL;
            cnt_q <= count;
            ptr   <= '0;
            vec_q <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        FILL: begin
          vec_q <= vec_nxt;
          ptr   <= ptr + STEP;
          if (ptr == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign vec = vec_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed and round-trip bench for ones_pattern_gen.
// Three instances share stimulus: CHUNK = 8, 1 and 127.
module tb_ones_pattern_gen;

  localparam int L = 127;

  logic         clk;
  logic         rst;
  logic         start;
  logic [6:0]   count;
  logic         busy8, done8, busy1, done1, busy127, done127;
  logic [L-1:0] vec8, vec1, vec127;

  int n_cmp = 0;
  int n_bad = 0;

  ones_pattern_gen #(.N(6), .CHUNK(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .busy(busy8), .done(done8), .vec(vec8)
  );

  ones_pattern_gen #(.N(6), .CHUNK(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .busy(busy1), .done(done1), .vec(vec1)
  );

  ones_pattern_gen #(.N(6), .CHUNK(127)) u127 (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .busy(busy127), .done(done127), .vec(vec127)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   c;
    logic [L-1:0] v;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [L-1:0] act,
                     input logic [L-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int pop(input logic [L-1:0] v);
    int s = 0;
    for (int i = 0; i < L; i++) s += int'(v[i]);
    return s;
  endfunction

  // Start at edge e=1; done must appear after e=17, busy seen 16 times.
  task automatic run8(input logic [6:0] c, input logic [L-1:0] exp);
    int de;
    int bc;
    count = c;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    de = 0;
    bc = busy8 ? 1 : 0;
    for (int e = 2; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (done8) begin
        de = e;
        break;
      end
      if (busy8) bc++;
    end
    chk($sformatf("done_edge c=%0d", c), L'(de), L'(17));
    chk($sformatf("busy_len c=%0d", c), L'(bc), L'(16));
    chk($sformatf("vec c=%0d", c), vec8, exp);
    chk($sformatf("busy_at_done c=%0d", c), L'(busy8), L'(0));
    @(posedge clk);
    #1;
    chk($sformatf("done_pulse c=%0d", c), L'(done8), L'(0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    count = '0;
    tbl[0] = '{7'd0,   127'h0};
    tbl[1] = '{7'd1,   127'h1};
    tbl[2] = '{7'd8,   127'hFF};
    tbl[3] = '{7'd9,   127'h1FF};
    tbl[4] = '{7'd64,  127'hFFFF_FFFF_FFFF_FFFF};
    tbl[5] = '{7'd120, 127'hFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
    tbl[6] = '{7'd127, ~127'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", L'(busy8), L'(0));
    chk("rst_done", L'(done8), L'(0));
    chk("rst_vec", vec8, L'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run8(tbl[i].c, tbl[i].v);

    // Chunk-boundary progress for count=9.
    count = 7'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    chk("c9_chunk0", L'(vec8[8:0]), L'(9'h0FF));
    @(posedge clk);
    #1;
    chk("c9_chunk1", L'(vec8[8]), L'(1));
    repeat (14) @(posedge clk);
    #1;
    chk("c9_done", L'(done8), L'(1));
    chk("c9_vec", vec8, L'(127'h1FF));
    @(posedge clk);
    #1;

    // Reset asserted mid-fill aborts immediately.
    count = 7'd100;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", L'(busy8), L'(0));
    chk("abort_done", L'(done8), L'(0));
    chk("abort_vec", vec8, L'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    run8(7'd5, 127'h1F);

    // Back-to-back with start held; count edits during FILL ignored.
    count = 7'd64;
    start = 1'b1;
    @(posedge clk);
    #1 count = 7'd3;
    repeat (16) @(posedge clk);
    #1;
    chk("b2b_done1", L'(done8), L'(1));
    chk("b2b_vec1", vec8, 127'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1;
    chk("b2b_nogap", L'(busy8), L'(1));
    chk("b2b_done_lo", L'(done8), L'(0));
    start = 1'b0;
    count = 7'd100;
    repeat (16) @(posedge clk);
    #1;
    chk("b2b_done2", L'(done8), L'(1));
    chk("b2b_vec2", vec8, L'(127'h7));
    @(posedge clk);
    #1;
    chk("b2b_done2_lo", L'(done8), L'(0));
    chk("b2b_idle", L'(busy8), L'(0));

    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Random round trip on all three chunk widths.
    for (int it = 0; it < 200; it++) begin
      int c;
      int bc8, bc1, bc127;
      bit g8, g1, g127;
      logic [L-1:0] r8, r1, r127;
      c = int'($urandom_range(0, 127));
      bc8 = 0; bc1 = 0; bc127 = 0;
      g8 = 0; g1 = 0; g127 = 0;
      r8 = '0; r1 = '0; r127 = '0;
      count = 7'(c);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 0; k < 300 && !(g8 && g1 && g127); k++) begin
        if (k > 0) begin
          @(posedge clk);
          #1;
        end
        if (!g8) begin
          if (busy8) bc8++;
          if (done8) begin g8 = 1; r8 = vec8; end
        end
        if (!g1) begin
          if (busy1) bc1++;
          if (done1) begin g1 = 1; r1 = vec1; end
        end
        if (!g127) begin
          if (busy127) bc127++;
          if (done127) begin g127 = 1; r127 = vec127; end
        end
      end
      if (!(g8 && g1 && g127)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rt_timeout c=%0d: got done %0b%0b%0b want 111",
                 c, g8, g1, g127);
      end else begin
        chk($sformatf("rt8_pop c=%0d", c), L'(pop(r8)), L'(c));
        chk($sformatf("rt1_pop c=%0d", c), L'(pop(r1)), L'(c));
        chk($sformatf("rt127_pop c=%0d", c), L'(pop(r127)), L'(c));
        chk($sformatf("rt8_busy c=%0d", c), L'(bc8), L'(16));
        chk($sformatf("rt1_busy c=%0d", c), L'(bc1), L'(127));
        chk($sformatf("rt127_busy c=%0d", c), L'(bc127), L'(1));
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
